// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between two byte sources: requester 0 (CPU UART
// MMIO) and requester 1 (hardware debug/trace port). Each byte is accepted in
// IDLE with a valid/ready handshake, held in an output register, and offered
// to the transmitter in SEND until tx_ready. Arbitration is round-robin with a
// bounded burst: the last-served requester may keep the line for up to
// MAX_BURST consecutive bytes while the other one is waiting.
//
// Parameters
//   MAX_BURST   max consecutive bytes for one requester while the other waits
//               (1..15)
//
// Ports
//   clk         system clock, all state on its rising edge
//   rst         asynchronous active-high reset
//   req0_data   byte from requester 0
//   req0_valid  requester 0 byte valid
//   req0_ready  requester 0 byte accepted this cycle
//   req1_data   byte from requester 1
//   req1_valid  requester 1 byte valid
//   req1_ready  requester 1 byte accepted this cycle
//   tx_data     byte to the UART transmitter
//   tx_valid    tx_data valid
//   tx_ready    transmitter accepts the byte
//   grant       one-hot owner of the byte in flight, 2'b00 when idle
//   cnt0        bytes delivered for requester 0 (wraps)
//   cnt1        bytes delivered for requester 1 (wraps)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  req0_data,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req1_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [1:0]  grant,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    state_t     state;
    state_t     state_next;

    logic [3:0] burst_cnt;
    logic       last_served;
    logic       other_waiting;

    logic       both_valid;
    logic       continue_burst;
    logic       sel;
    logic       accept;
    logic       handoff;
    logic       owner;

    // Requester selection for the IDLE cycle.
    // A burst count of zero means no burst is in progress (either just out of
    // reset or the previous byte was sent with nobody else waiting), so the
    // round-robin pointer alone decides. Only a live, unfinished burst lets
    // the last-served requester go again ahead of a waiting competitor.
    always_comb begin
        both_valid     = req0_valid && req1_valid;
        continue_burst = (burst_cnt != 4'd0) && (burst_cnt < BURST_LIMIT);
        sel            = 1'b0;
        if (both_valid) begin
            sel = continue_burst ? last_served : ~last_served;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    // The readys depend only on the state and the request inputs, never on
    // tx_ready, so a SEND handoff and a new accept can never share a cycle.
    // The readys are also gated by rst so nothing is accepted while reset is
    // held, even though the state is already IDLE.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        handoff    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    req0_ready = ~sel;
                    req1_ready = sel;
                    accept     = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    handoff    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The owner of the byte in flight is recovered from the one-hot grant.
    always_comb begin
        owner = grant[1];
    end

    // Output byte register, grant and the "was anybody else waiting" flag.
    // other_waiting remembers whether the losing requester had valid high at
    // the moment of acceptance; it decides later whether this byte counts
    // towards a throttled burst at all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            grant         <= 2'b00;
            other_waiting <= 1'b0;
        end else begin
            if (accept) begin
                tx_data       <= sel ? req1_data : req0_data;
                tx_valid      <= 1'b1;
                grant         <= sel ? 2'b10 : 2'b01;
                other_waiting <= both_valid;
            end else if (handoff) begin
                tx_valid <= 1'b0;
                grant    <= 2'b00;
            end
        end
    end

    // Delivered-byte counters, bumped only when the transmitter takes the
    // byte. A byte dropped by reset mid-SEND is therefore never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= 16'h0000;
            cnt1 <= 16'h0000;
        end else if (handoff) begin
            if (owner) begin
                cnt1 <= cnt1 + 16'd1;
            end else begin
                cnt0 <= cnt0 + 16'd1;
            end
        end
    end

    // Round-robin pointer and burst tracking, updated at the SEND handoff.
    // Reset leaves requester 1 as last-served so requester 0 wins first.
    // A byte sent while the other side was not waiting clears the burst so a
    // lone requester never gets throttled; otherwise a new owner starts a
    // burst of one and the same owner extends it, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_served <= 1'b1;
            burst_cnt   <= 4'd0;
        end else if (handoff) begin
            last_served <= owner;
            if (!other_waiting) begin
                burst_cnt <= 4'd0;
            end else if (owner != last_served) begin
                burst_cnt <= 4'd1;
            end else if (burst_cnt < BURST_LIMIT) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. Two instances are used: "dut" with
// the default MAX_BURST of 4 for most scenarios, and "dut_rr" with MAX_BURST=1
// where a burst can never extend past one byte, giving strict alternation.
// Requesters are modelled as byte queues; expected {grant, data} entries are
// pushed when stimulus is loaded and popped when the transmitter takes a byte.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Main instance signals.
    logic [7:0]  req0_data = 8'h00;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [7:0]  req1_data = 8'h00;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [1:0]  grant;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    // Round-robin instance signals.
    logic [7:0]  rr_req0_data = 8'hA0;
    logic        rr_req0_valid = 1'b0;
    logic        rr_req0_ready;
    logic [7:0]  rr_req1_data = 8'hB1;
    logic        rr_req1_valid = 1'b0;
    logic        rr_req1_ready;
    logic [7:0]  rr_tx_data;
    logic        rr_tx_valid;
    logic        rr_tx_ready = 1'b1;
    logic [1:0]  rr_grant;
    logic [15:0] rr_cnt0;
    logic [15:0] rr_cnt1;

    // Bench state.
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    exp_t        exp_q[$];
    logic        en0 = 1'b1;
    logic        en1 = 1'b1;
    logic [15:0] mcnt0 = 16'h0000;
    logic [15:0] mcnt1 = 16'h0000;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    logic        have_last = 1'b0;
    logic        check_gap = 1'b0;

    uart_tx_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .grant      (grant),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    uart_tx_arbiter #(.MAX_BURST(1)) dut_rr (
        .clk        (clk),
        .rst        (rst),
        .req0_data  (rr_req0_data),
        .req0_valid (rr_req0_valid),
        .req0_ready (rr_req0_ready),
        .req1_data  (rr_req1_data),
        .req1_valid (rr_req1_valid),
        .req1_ready (rr_req1_ready),
        .tx_data    (rr_tx_data),
        .tx_valid   (rr_tx_valid),
        .tx_ready   (rr_tx_ready),
        .grant      (rr_grant),
        .cnt0       (rr_cnt0),
        .cnt1       (rr_cnt1)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Queue a byte at a requester.
    task automatic applyStimulus(input int which, input logic [7:0] data);
        if (which == 0) q0.push_back(data);
        else            q1.push_back(data);
    endtask

    // Record the byte the transmitter must receive next.
    task automatic expectByte(input logic [1:0] g, input logic [7:0] data);
        exp_t e;
        e.grant = g;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // Present the head of each requester queue.
    task automatic driveRequesters();
        req0_valid = en0 && (q0.size() != 0);
        req0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
        req1_valid = en1 && (q1.size() != 0);
        req1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    // One clock cycle: sample at negedge (scoreboard + handshakes), then
    // update requester queues just after the rising edge.
    task automatic stepCycle();
        exp_t e;
        logic hs0;
        logic hs1;
        @(negedge clk);
        cyc++;
        if (tx_valid && tx_ready) begin
            checkOutput("readys_at_handoff", {30'd0, req0_ready, req1_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("sb_underflow", exp_q.size(), 32'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_grant", {30'd0, grant}, {30'd0, e.grant});
                checkOutput("sb_data", {24'd0, tx_data}, {24'd0, e.data});
                if (e.grant[1]) mcnt1 = mcnt1 + 16'd1;
                else            mcnt0 = mcnt0 + 16'd1;
                if (check_gap && have_last)
                    checkOutput("byte_spacing", cyc - last_hs_cyc, 32'd2);
                last_hs_cyc = cyc;
                have_last   = 1'b1;
            end
        end
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        driveRequesters();
    endtask

    // Step until every expected byte has been delivered, within a budget.
    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_drain"}, exp_q.size(), 32'd0);
    endtask

    // Synchronous-looking reset pulse that returns at posedge+1.
    task automatic applyReset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        mcnt0     = 16'h0000;
        mcnt1     = 16'h0000;
        have_last = 1'b0;
        en0       = 1'b1;
        en1       = 1'b1;
        driveRequesters();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int handoffs;
        int last_c;
        int bad;
        driveRequesters();

        // ---- Reset state, both round-robin requesters valid throughout ----
        rr_req0_valid = 1'b1;
        rr_req1_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("rst_grant", {30'd0, grant}, 32'd0);
        checkOutput("rst_cnt0", {16'd0, cnt0}, 32'd0);
        checkOutput("rst_cnt1", {16'd0, cnt1}, 32'd0);
        checkOutput("rst_rr_readys", {30'd0, rr_req0_ready, rr_req1_ready}, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("rst_rr_no_accept", {31'd0, rr_tx_valid}, 32'd0);
        rst = 1'b0;

        // ---- Strict alternation with MAX_BURST=1, tx_ready held high ----
        handoffs = 0;
        last_c   = 0;
        for (int c = 1; c <= 40 && handoffs < 8; c++) begin
            @(negedge clk);
            if (rr_tx_valid && rr_tx_ready) begin
                checkOutput("rr_grant", {30'd0, rr_grant},
                            (handoffs % 2 == 0) ? 32'd1 : 32'd2);
                checkOutput("rr_data", {24'd0, rr_tx_data},
                            (handoffs % 2 == 0) ? 32'hA0 : 32'hB1);
                if (handoffs > 0) checkOutput("rr_spacing", c - last_c, 32'd2);
                last_c = c;
                handoffs++;
            end
        end
        checkOutput("rr_handoffs", handoffs, 32'd8);
        @(negedge clk);
        checkOutput("rr_cnt0", {16'd0, rr_cnt0}, 32'd4);
        checkOutput("rr_cnt1", {16'd0, rr_cnt1}, 32'd4);
        rr_req0_valid = 1'b0;
        rr_req1_valid = 1'b0;

        // ---- Lone requester 1, 20 bytes, never throttled ----
        applyReset();
        check_gap = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 8'h61 + 8'(i));
            expectByte(2'b10, 8'h61 + 8'(i));
        end
        driveRequesters();
        waitDrain("lone1", 100);
        checkOutput("lone1_cnt1", {16'd0, cnt1}, 32'd20);
        checkOutput("lone1_cnt0", {16'd0, cnt0}, 32'd0);
        check_gap = 1'b0;

        // ---- Burst behaviour with MAX_BURST=4 ----
        applyReset();
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h02);
        expectByte(2'b01, 8'h01);
        expectByte(2'b01, 8'h02);
        driveRequesters();
        waitDrain("solo0", 20);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h03 + 8'(i));
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'h11 + 8'(i));
        for (int i = 0; i < 4; i++) expectByte(2'b10, 8'h11 + 8'(i));
        for (int i = 0; i < 4; i++) expectByte(2'b01, 8'h03 + 8'(i));
        expectByte(2'b10, 8'h15);
        driveRequesters();
        waitDrain("burst", 100);
        checkOutput("burst_cnt0", {16'd0, cnt0}, 32'd6);
        checkOutput("burst_cnt1", {16'd0, cnt1}, 32'd5);

        // ---- Stall in SEND, requester 1 drops valid before grant ----
        tx_ready = 1'b0;
        applyStimulus(0, 8'h5A);
        expectByte(2'b01, 8'h5A);
        driveRequesters();
        for (int n = 0; n < 10 && !tx_valid; n++) stepCycle();
        checkOutput("hold_enter", {31'd0, tx_valid}, 32'd1);
        applyStimulus(1, 8'h77);
        expectByte(2'b10, 8'h77);
        driveRequesters();
        bad = 0;
        for (int n = 0; n < 50; n++) begin
            if (n == 25) begin
                en1 = 1'b0;
                driveRequesters();
            end
            stepCycle();
            if (tx_data !== 8'h5A || grant !== 2'b01 || tx_valid !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
                cnt0 !== mcnt0 || cnt1 !== mcnt1)
                bad++;
        end
        checkOutput("hold_stable", bad, 32'd0);
        tx_ready = 1'b1;
        stepCycle();
        tx_ready = 1'b0;
        repeat (3) stepCycle();
        checkOutput("pulse_cnt0", {16'd0, cnt0}, 32'd7);
        checkOutput("pulse_cnt1", {16'd0, cnt1}, {16'd0, mcnt1});
        checkOutput("pulse_idle", {31'd0, tx_valid}, 32'd0);
        checkOutput("dropped_pending", exp_q.size(), 32'd1);
        en1 = 1'b1;
        driveRequesters();
        tx_ready = 1'b1;
        waitDrain("late1", 20);
        checkOutput("late1_cnt1", {16'd0, cnt1}, 32'd6);

        // ---- Asynchronous reset in the middle of SEND ----
        tx_ready = 1'b0;
        applyStimulus(0, 8'hC3);
        expectByte(2'b01, 8'hC3);
        driveRequesters();
        for (int n = 0; n < 10 && !tx_valid; n++) stepCycle();
        checkOutput("arst_enter", {31'd0, tx_valid}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("arst_grant", {30'd0, grant}, 32'd0);
        checkOutput("arst_tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("arst_cnt0", {16'd0, cnt0}, 32'd0);
        checkOutput("arst_cnt1", {16'd0, cnt1}, 32'd0);
        exp_q.delete();
        q0.delete();
        q1.delete();
        mcnt0     = 16'h0000;
        mcnt1     = 16'h0000;
        have_last = 1'b0;
        applyStimulus(0, 8'hD0);
        applyStimulus(1, 8'hE0);
        expectByte(2'b01, 8'hD0);
        expectByte(2'b10, 8'hE0);
        driveRequesters();
        #1;
        checkOutput("arst_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("arst_no_accept", {31'd0, tx_valid}, 32'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        waitDrain("post_rst", 20);
        checkOutput("post_rst_cnt0", {16'd0, cnt0}, 32'd1);
        checkOutput("post_rst_cnt1", {16'd0, cnt1}, 32'd1);

        // ---- Counter wrap from 16'hFFFF ----
        force dut.cnt0 = 16'hFFFF;
        #2;
        release dut.cnt0;
        mcnt0 = 16'hFFFF;
        checkOutput("wrap_preload", {16'd0, cnt0}, 32'h0000FFFF);
        applyStimulus(0, 8'h99);
        expectByte(2'b01, 8'h99);
        driveRequesters();
        waitDrain("wrap", 20);
        checkOutput("wrap_cnt0", {16'd0, cnt0}, 32'd0);
        checkOutput("wrap_model_cnt0", {16'd0, cnt0}, {16'd0, mcnt0});
        checkOutput("wrap_cnt1", {16'd0, cnt1}, {16'd0, mcnt1});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
